// File: rtl/serial_fft_pkg.sv
// Shared definitions for the serial single-bin DFT datapath and its consumers:
// default widths, the averaging FSM state type and an unsigned saturation helper.
package serial_fft_pkg;

  localparam int S_WIDTH_DEF = 32;
  localparam int P_WIDTH_DEF = 64;

  // Widest value sat_u can take; callers zero-extend their operand to this width.
  localparam int SAT_MAX_W = 256;

  typedef enum logic {
    ACCUM = 1'b0,
    LAST  = 1'b1
  } avg_state_t;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] value;
  } sat_t;

  // Clamp value to the largest unsigned number representable in width bits.
  function automatic sat_t sat_u(input logic [SAT_MAX_W-1:0] value, input int width);
    sat_t res;
    res.ovf   = 1'b0;
    res.value = value;
    if (width < SAT_MAX_W && (value >> width) != '0) begin
      res.ovf   = 1'b1;
      res.value = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_fft_bin_power_cplx_mag_sq.sv
// Two-stage |re + j*im|^2: squares in the first stage, their sum in the second.
// A clear pulse kills both valid bits so in-flight samples never leave the block.
module cplx_mag_sq
  import serial_fft_pkg::*;
#(
  parameter int S_WIDTH = S_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 valid,
  input  logic [S_WIDTH-1:0]   re,
  input  logic [S_WIDTH-1:0]   im,
  output logic                 p_valid,
  output logic [2*S_WIDTH:0]   p
);

  logic [2*S_WIDTH-1:0] re_ext;
  logic [2*S_WIDTH-1:0] im_ext;
  logic [2*S_WIDTH-1:0] sq_re;
  logic [2*S_WIDTH-1:0] sq_im;
  logic                 sq_valid;

  // Sign-extend to full product width so (-2^(S_WIDTH-1))^2 stays exact.
  assign re_ext = {{S_WIDTH{re[S_WIDTH-1]}}, re};
  assign im_ext = {{S_WIDTH{im[S_WIDTH-1]}}, im};

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_valid <= 1'b0;
      p_valid  <= 1'b0;
    end else begin
      sq_valid <= valid & ~clear;
      p_valid  <= sq_valid & ~clear;
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    sq_re <= re_ext * re_ext;
    sq_im <= im_ext * im_ext;
    p     <= {1'b0, sq_re} + {1'b0, sq_im};
  end

endmodule

// File: rtl/serial_fft_bin_power.sv
// Bin power estimator: |X|^2 per DFT frame, averaged over 2^AVG_LOG2 frames,
// saturated to P_WIDTH bits and emitted as a single-cycle pulse per group.
module serial_fft_bin_power
  import serial_fft_pkg::*;
#(
  parameter int S_WIDTH  = S_WIDTH_DEF,
  parameter int P_WIDTH  = P_WIDTH_DEF,
  parameter int AVG_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      valid_i,
  input  logic signed [S_WIDTH-1:0] re,
  input  logic signed [S_WIDTH-1:0] im,
  output logic                      valid_o,
  output logic [P_WIDTH-1:0]        power,
  output logic                      ovf_o
);

  localparam int SUM_W = 2 * S_WIDTH + 1;
  localparam int ACC_W = SUM_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  // Counter value whose increment moves the FSM into LAST.
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((1 << AVG_LOG2) - 2);

  logic               p_valid;
  logic [SUM_W-1:0]   p;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;
  logic [SUM_W-1:0]   avg;
  logic [CNT_W-1:0]   cnt;
  avg_state_t         state;
  sat_t               sat;
  logic               group_done;

  cplx_mag_sq #(
    .S_WIDTH (S_WIDTH)
  ) u_mag_sq (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_i),
    .valid   (valid_i),
    .re      (re),
    .im      (im),
    .p_valid (p_valid),
    .p       (p)
  );

  assign sum        = acc + ACC_W'(p);
  assign avg        = SUM_W'(sum >> AVG_LOG2);
  assign sat        = sat_u(SAT_MAX_W'(avg), P_WIDTH);
  // Without averaging every sample closes its own group.
  assign group_done = p_valid && (AVG_LOG2 == 0 || state == LAST);

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      cnt     <= '0;
      acc     <= '0;
      valid_o <= 1'b0;
      power   <= '0;
      ovf_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (clear_i) begin
        state <= ACCUM;
        cnt   <= '0;
        acc   <= '0;
      end else if (group_done) begin
        state   <= ACCUM;
        cnt     <= '0;
        acc     <= '0;
        valid_o <= 1'b1;
        power   <= P_WIDTH'(sat.value);
        ovf_o   <= sat.ovf;
      end else if (p_valid) begin
        cnt   <= cnt + CNT_W'(1);
        acc   <= sum;
        state <= (cnt == PRE_LAST) ? LAST : ACCUM;
      end
    end
  end

endmodule
